// File: rtl/func_sweep_ctrl_if.sv
// Result channel of the sweep controller: one valid/ready word carrying
// the stimulus value, the captured response and the sample index.
interface func_sweep_ctrl_if #(
    parameter int WIDTH = 24,
    parameter int CNT_W = 16
);
    logic                    res_valid;
    logic                    res_ready;
    logic signed [WIDTH-1:0] res_in;
    logic signed [WIDTH-1:0] res_out;
    logic [CNT_W-1:0]        res_idx;

    modport master (
        output res_valid,
        input  res_ready,
        output res_in,
        output res_out,
        output res_idx
    );

    modport slave (
        input  res_valid,
        output res_ready,
        input  res_in,
        input  res_out,
        input  res_idx
    );
endinterface

// File: rtl/func_sweep_ctrl.sv
// Function sweep controller: steps a signed stimulus from start_val to
// stop_val, waits a settle time for the datapath, captures its response
// and offers each (stimulus, response, index) word on a valid/ready channel.
module func_sweep_ctrl #(
    parameter int WIDTH = 24,
    parameter int CNT_W = 16
) (
    input  logic                    emu_clk,
    input  logic                    emu_rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic signed [WIDTH-1:0] start_val,
    input  logic signed [WIDTH-1:0] stop_val,
    input  logic signed [WIDTH-1:0] step_val,
    input  logic [CNT_W-1:0]        settle,
    output logic signed [WIDTH-1:0] in_,
    input  logic signed [WIDTH-1:0] out,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        n_samp,
    func_sweep_ctrl_if.master       res
);

    typedef enum logic [1:0] {IDLE, SETTLE, OFFER, DONE} state_t;

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] in_q, in_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        idx_q, idx_d;
    logic                    res_valid_q, res_valid_d;
    logic signed [WIDTH-1:0] res_in_q, res_in_d;
    logic signed [WIDTH-1:0] res_out_q, res_out_d;
    logic [CNT_W-1:0]        res_idx_q, res_idx_d;
    logic [CNT_W-1:0]        n_samp_q, n_samp_d;

    // One extra bit so in_ + step_val cannot wrap before the stop compare.
    logic signed [WIDTH:0]   next_w;
    logic signed [WIDTH:0]   stop_w;
    logic                    hshake;

    assign next_w = $signed({in_q[WIDTH-1], in_q}) + $signed({step_val[WIDTH-1], step_val});
    assign stop_w = $signed({stop_val[WIDTH-1], stop_val});
    assign hshake = res_valid_q && res.res_ready;

    // Next-state and datapath update; abort overrides every other action.
    always_comb begin
        state_d     = state_q;
        in_d        = in_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        res_valid_d = res_valid_q;
        res_in_d    = res_in_q;
        res_out_d   = res_out_q;
        res_idx_d   = res_idx_q;
        n_samp_d    = n_samp_q;
        if (abort) begin
            state_d     = IDLE;
            res_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        idx_d = '0;
                        if (start_val <= stop_val) begin
                            in_d    = start_val;
                            cnt_d   = settle;
                            state_d = SETTLE;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
                        res_out_d   = out;
                        res_in_d    = in_q;
                        res_idx_d   = idx_q;
                        res_valid_d = 1'b1;
                        state_d     = OFFER;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                OFFER: begin
                    if (hshake) begin
                        res_valid_d = 1'b0;
                        idx_d       = idx_q + 1'b1;
                        if (next_w > stop_w || idx_q == '1) begin
                            state_d = DONE;
                        end else begin
                            in_d    = next_w[WIDTH-1:0];
                            cnt_d   = settle;
                            state_d = SETTLE;
                        end
                    end
                end
                DONE: begin
                    n_samp_d = idx_q;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge emu_clk or posedge emu_rst) begin
        if (emu_rst) begin
            state_q     <= IDLE;
            in_q        <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            res_valid_q <= 1'b0;
            res_in_q    <= '0;
            res_out_q   <= '0;
            res_idx_q   <= '0;
            n_samp_q    <= '0;
        end else begin
            state_q     <= state_d;
            in_q        <= in_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            res_valid_q <= res_valid_d;
            res_in_q    <= res_in_d;
            res_out_q   <= res_out_d;
            res_idx_q   <= res_idx_d;
            n_samp_q    <= n_samp_d;
        end
    end

    assign in_           = in_q;
    assign busy          = (state_q == SETTLE) || (state_q == OFFER);
    assign done          = (state_q == DONE);
    assign n_samp        = n_samp_q;
    assign res.res_valid = res_valid_q;
    assign res.res_in    = res_in_q;
    assign res.res_out   = res_out_q;
    assign res.res_idx   = res_idx_q;

endmodule
